// File: rtl/subtractor_serial_8.sv
// Bit-serial subtractor D = A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: done pulses WIDTH cycles after the accepting start edge; one result per WIDTH+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; requests while busy are dropped, not queued.
module subtractor_serial_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   D,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH:0]   d_q, d_d;
  logic             busy_q, done_q;

  // Single full-subtractor cell working on the current LSBs of the operand shifters.
  logic a_bit, b_bit, diff, borrow_nxt, last_bit;
  always_comb begin
    a_bit      = a_q[0];
    b_bit      = b_q[0];
    diff       = a_bit ^ b_bit ^ borrow_q;
    borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    last_bit   = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control; start is honoured only outside RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          r_d      = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Diff enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        r_d      = {diff, r_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          d_d     = {borrow_nxt, diff, r_q[WIDTH-1:1]};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign D    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_subtractor_serial_8.sv
// Bench for subtractor_serial_8: directed vectors, expected results queued at issue time.
// A negedge monitor pops one expectation per done pulse and compares D.
// Stimulus also checks busy/done cycle by cycle and the reset/abort behaviour.
module tb_subtractor_serial_8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A, B;
  logic [8:0] D;
  logic       busy, done;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  subtractor_serial_8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .D     (D),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got D=%h with no pending result at %0t", D, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (D !== e) begin
          errors++;
          $display("FAIL result: got D=%h expected %h at %0t", D, e, $time);
        end
      end
    end
  end

  // One operation with start pulsed for the accepting edge only; checks busy/done timing.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
    start = 1'b1; A = a; B = b;
    exp_q.push_back(e);
    @(posedge clk); #1;             // edge 0 accepted, now cycle 1
    start = 1'b0; A = ~a; B = ~b;   // operand changes must not matter
    for (int c = 1; c <= 8; c++) begin
      check("busy_run", {8'd0, busy}, 9'd1);
      check("done_run", {8'd0, done}, 9'd0);
      @(posedge clk); #1;
    end
    check("done_pulse", {8'd0, done}, 9'd1);   // cycle 9
    check("busy_done",  {8'd0, busy}, 9'd0);
    @(posedge clk); #1;
    check("done_clear", {8'd0, done}, 9'd0);
    check("d_held",     D, e);
    @(posedge clk); #1;
    check("d_held_idle", D, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b1; A = 8'hFF; B = 8'h01;
    // Reset held two cycles with start asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_D",    D, 9'h000);
      check("rst_busy", {8'd0, busy}, 9'd0);
      check("rst_done", {8'd0, done}, 9'd0);
    end
    start = 1'b0; reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_busy", {8'd0, busy}, 9'd0);
    end

    // Basic and boundary vectors.
    do_op(8'hFF, 8'h01, 9'h0FE);
    do_op(8'h00, 8'h01, 9'h1FF);
    do_op(8'h80, 8'h80, 9'h000);
    do_op(8'h00, 8'hFF, 9'h101);

    // Start pulse mid-RUN must be ignored and not queued.
    start = 1'b1; A = 8'h0F; B = 8'h03;
    exp_q.push_back(9'h00C);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; A = 8'h00; B = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_no_queue", {8'd0, busy}, 9'd0);
    check("d_after_ignored", D, 9'h00C);
    check("queue_drained", 9'(exp_q.size()), 9'd0);

    // Reset during RUN aborts with no done and clears D.
    start = 1'b1; A = 8'h55; B = 8'hAA;
    @(posedge clk); #1;             // edge 0
    start = 1'b0;
    repeat (3) @(posedge clk);      // edges 1..3
    #1; reset = 1'b1;
    @(posedge clk); #1;             // edge 4 resets
    reset = 1'b0;
    check("abort_D",    D, 9'h000);
    check("abort_busy", {8'd0, busy}, 9'd0);
    check("abort_done", {8'd0, done}, 9'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_idle_busy", {8'd0, busy}, 9'd0);
    do_op(8'h55, 8'hAA, 9'h1AB);

    // Back-to-back with start held high; operands change during the done cycle.
    start = 1'b1; A = 8'h10; B = 8'h01;
    exp_q.push_back(9'h00F);
    @(posedge clk); #1;             // edge 0, cycle 1
    for (int c = 1; c <= 18; c++) begin
      check("b2b_busy", {8'd0, busy}, {8'd0, (c != 9 && c != 18)});
      check("b2b_done", {8'd0, done}, {8'd0, (c == 9 || c == 18)});
      if (c == 9) begin
        A = 8'h01; B = 8'h10;
        exp_q.push_back(9'h1F1);
      end
      if (c == 10) start = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_final_D", D, 9'h1F1);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", {8'd0, busy}, 9'd0);
    check("all_results_seen", 9'(exp_q.size()), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subtractor_serial_8.md
Name: subtractor_serial_8

Overview:
- Sequential, bit-serial subtractor. It computes D = A - B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the 8-bit ripple-carry adder. It trades latency for area, using one cell instead of WIDTH cells.
- Operands are captured on a start handshake. The result is reported with a one-cycle done pulse and held until the next result completes.

Parameters:
- WIDTH, 8, operand width in bits. Result width is WIDTH+1. Minimum value is 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- A  input  WIDTH  minuend; sampled on the accepting start edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting start edge only.
- D  output  WIDTH+1  result. D[WIDTH-1:0] = (A - B) mod 2^WIDTH; D[WIDTH] = borrow out (1 iff A < B). D equals the (WIDTH+1)-bit two's-complement of A - B.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; D is valid and new.

Behaviour:
- Reset:
  - Only one clock and one reset exist. Reset is synchronous and active-high, sampled on the rising edge of clk.
  - At reset: state=IDLE, D=0, busy=0, done=0. The bit counter, borrow flip-flop and operand/result shift registers are cleared.
  - Reset overrides start and any in-flight operation. Reset mid-RUN aborts, produces no done pulse, and clears D to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: capture A and B into shift registers, set counter=0 and borrow=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1, done=0.
  - Each edge computes bit i = counter:
    - diff = a_i XOR b_i XOR borrow
    - borrow_next = (~a_i & b_i) | (~(a_i XOR b_i) & borrow)
  - diff is shifted into the result register, the operand registers shift right, and counter increments.
  - On the edge processing i = WIDTH-1: load D = {borrow_next, result bits}, go to DONE.
  - start is ignored throughout RUN. Input changes to A or B during RUN have no effect.
- DONE:
  - busy=0, done=1 for exactly one cycle. D holds the new result.
  - Next edge: if start=1, capture new operands and go to RUN (back-to-back accepted with no idle cycle). Otherwise go to IDLE.
- Latency:
  - Start is accepted at edge 0. Edges 1..WIDTH process bits 0..WIDTH-1.
  - done is high in the cycle following edge WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Throughput: one result per WIDTH+1 cycles when start is held high.
- D is updated only on the transition RUN->DONE (or by reset). During RUN and IDLE, D holds the previous result.
- Arithmetic is unsigned modular with an explicit borrow. No saturation.
- Boundary results:
  - A = B gives D = 0.
  - A = 0, B = 2^WIDTH-1 gives D = {1, 0...01}.
  - Wrap-around is reported only via D[WIDTH].
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset value: assert reset 2 cycles with start=1, A=8'hFF, B=8'h01. Required: D=9'h000, busy=0, done=0 throughout. No operation starts after reset deasserts until start is sampled in IDLE.
- Basic borrow-free: A=8'hFF, B=8'h01, start pulse at edge 0. Required: busy=1 for cycles 1-8; done=1 in cycle 9 only; D=9'h0FE from cycle 9 and held in IDLE.
- Full borrow ripple: A=8'h00, B=8'h01. Required: D=9'h1FF at done. Then A=8'h80, B=8'h80 gives D=9'h000. Then A=8'h00, B=8'hFF gives D=9'h101.
- Start/operand changes while busy: issue A=8'h0F, B=8'h03. Mid-RUN pulse start with A=8'h00, B=8'hFF. Required: only one done, D=9'h00C, and the second request is not queued.
- Reset mid-operation: start A=8'h55, B=8'hAA, assert reset at cycle 4. Required: no done pulse, D=9'h000, state IDLE. A fresh start afterwards gives D=9'h1AB.
- Back-to-back: hold start=1 with A=8'h10, B=8'h01, then change to A=8'h01, B=8'h10 during the done cycle. Required: done pulses in cycles 9 and 18; D=9'h00F, then 9'h1F1; busy low only in the done cycles.
